mem_arbiter: RTL

- Shares one external memory port between NUM_REQS cache memory-side masters (the instruction cache and the data cache on the memory side).
- Request path: round-robin grant, requester index appended to the low bits of the tag, one registered output stage.
- Response path: routed back to the originating cache by the low tag bits.
- Sits between the cache memory interfaces and the memory/AXI bridge.

---
 rtl/mem_arb_pkg.sv | 24 ++
 rtl/mem_arb_if.sv | 48 ++++
 rtl/mem_arbiter_chk.sv | 26 ++
 rtl/rr_arbiter.sv | 53 +++++
 rtl/mem_arbiter.sv | 98 +++++++++
 5 files changed

// File: rtl/mem_arb_pkg.sv
// Shared widths and the registered memory-request payload type for mem_arbiter.
package mem_arb_pkg;

    function automatic int sel_bits_f(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

    localparam int NUM_REQS      = 2;
    localparam int ADDR_WIDTH    = 26;
    localparam int DATA_WIDTH    = 512;
    localparam int BYTEEN_WIDTH  = DATA_WIDTH / 8;
    localparam int TAG_IN_WIDTH  = 8;
    localparam int SEL_BITS      = sel_bits_f(NUM_REQS);
    localparam int TAG_OUT_WIDTH = TAG_IN_WIDTH + SEL_BITS;

    typedef struct packed {
        logic                     rw;
        logic [BYTEEN_WIDTH-1:0]  byteen;
        logic [ADDR_WIDTH-1:0]    addr;
        logic [DATA_WIDTH-1:0]    data;
        logic [TAG_OUT_WIDTH-1:0] tag;
    } mem_req_t;

endpackage

// File: rtl/mem_arb_if.sv
// Cache-side and memory-side buses of mem_arbiter; slave = arbiter view, master = environment view.
interface mem_arb_if;
    import mem_arb_pkg::*;

    logic [NUM_REQS-1:0]              req_valid_i;
    logic [NUM_REQS-1:0]              req_rw_i;
    logic [NUM_REQS*BYTEEN_WIDTH-1:0] req_byteen_i;
    logic [NUM_REQS*ADDR_WIDTH-1:0]   req_addr_i;
    logic [NUM_REQS*DATA_WIDTH-1:0]   req_data_i;
    logic [NUM_REQS*TAG_IN_WIDTH-1:0] req_tag_i;
    logic [NUM_REQS-1:0]              req_ready_o;
    logic [NUM_REQS-1:0]              rsp_valid_o;
    logic [DATA_WIDTH-1:0]            rsp_data_o;
    logic [TAG_IN_WIDTH-1:0]          rsp_tag_o;
    logic [NUM_REQS-1:0]              rsp_ready_i;
    logic                             mem_req_valid_o;
    logic                             mem_req_rw_o;
    logic [BYTEEN_WIDTH-1:0]          mem_req_byteen_o;
    logic [ADDR_WIDTH-1:0]            mem_req_addr_o;
    logic [DATA_WIDTH-1:0]            mem_req_data_o;
    logic [TAG_OUT_WIDTH-1:0]         mem_req_tag_o;
    logic                             mem_req_ready_i;
    logic                             mem_rsp_valid_i;
    logic [DATA_WIDTH-1:0]            mem_rsp_data_i;
    logic [TAG_OUT_WIDTH-1:0]         mem_rsp_tag_i;
    logic                             mem_rsp_ready_o;

    modport slave (
        input  req_valid_i, req_rw_i, req_byteen_i, req_addr_i, req_data_i, req_tag_i,
        output req_ready_o, rsp_valid_o, rsp_data_o, rsp_tag_o,
        input  rsp_ready_i,
        output mem_req_valid_o, mem_req_rw_o, mem_req_byteen_o, mem_req_addr_o,
        output mem_req_data_o, mem_req_tag_o,
        input  mem_req_ready_i, mem_rsp_valid_i, mem_rsp_data_i, mem_rsp_tag_i,
        output mem_rsp_ready_o
    );

    modport master (
        output req_valid_i, req_rw_i, req_byteen_i, req_addr_i, req_data_i, req_tag_i,
        input  req_ready_o, rsp_valid_o, rsp_data_o, rsp_tag_o,
        output rsp_ready_i,
        input  mem_req_valid_o, mem_req_rw_o, mem_req_byteen_o, mem_req_addr_o,
        input  mem_req_data_o, mem_req_tag_o,
        output mem_req_ready_i, mem_rsp_valid_i, mem_rsp_data_i, mem_rsp_tag_i,
        input  mem_rsp_ready_o
    );

endinterface

// File: rtl/mem_arbiter_chk.sv
// Protocol checks for mem_arbiter: output stability under stall, single accept, response routing range.
module mem_arbiter_chk
    import mem_arb_pkg::*;
(
    input logic                clk_i,
    input logic                rst_ni,
    input logic                mem_req_valid_i,
    input logic                mem_req_ready_i,
    input mem_req_t            payload_i,
    input logic [NUM_REQS-1:0] req_ready_i,
    input logic                mem_rsp_valid_i,
    input logic [SEL_BITS-1:0] rsp_sel_i
);

    a_stall_hold: assert property (@(posedge clk_i) disable iff (!rst_ni)
        (mem_req_valid_i && !mem_req_ready_i) |=> (mem_req_valid_i && $stable(payload_i)))
        else $error("mem_arbiter: request changed while stalled");

    a_one_accept: assert property (@(posedge clk_i) disable iff (!rst_ni) $onehot0(req_ready_i))
        else $error("mem_arbiter: more than one requester accepted");

    a_rsp_sel: assert property (@(posedge clk_i) disable iff (!rst_ni)
        mem_rsp_valid_i |-> (int'(rsp_sel_i) < NUM_REQS))
        else $error("mem_arbiter: response tag selects no requester, dropped");

endmodule

// File: rtl/rr_arbiter.sv
// Round-robin arbiter: combinational grant, pointer advances to the winner when en_i consumes a grant.
module rr_arbiter #(
    parameter  int NUM_REQS = 2,
    localparam int IDX_W    = (NUM_REQS > 1) ? $clog2(NUM_REQS) : 1
) (
    input  logic                clk_i,
    input  logic                rst_ni,
    input  logic [NUM_REQS-1:0] req_i,
    input  logic                en_i,
    output logic                grant_valid_o,
    output logic [NUM_REQS-1:0] grant_onehot_o,
    output logic [IDX_W-1:0]    grant_idx_o
);

    logic [IDX_W-1:0]    last_grant_q;
    logic [NUM_REQS-1:0] hi_mask_s;
    logic [NUM_REQS-1:0] hi_req_s;
    logic [IDX_W-1:0]    grant_idx_s;

    function automatic logic [IDX_W-1:0] lowest_set_f(input logic [NUM_REQS-1:0] v);
        logic [IDX_W-1:0] idx;
        idx = '0;
        for (int i = NUM_REQS - 1; i >= 0; i--) begin
            if (v[i]) idx = IDX_W'(i);
        end
        return idx;
    endfunction

    // Requests above the last winner take priority; otherwise wrap to the lowest index.
    always_comb begin
        hi_mask_s = '0;
        for (int i = 0; i < NUM_REQS; i++) begin
            hi_mask_s[i] = (i > int'(last_grant_q));
        end
        hi_req_s    = req_i & hi_mask_s;
        grant_idx_s = (|hi_req_s) ? lowest_set_f(hi_req_s) : lowest_set_f(req_i);
    end

    assign grant_valid_o  = |req_i;
    assign grant_idx_o    = grant_idx_s;
    assign grant_onehot_o = grant_valid_o ? ({{(NUM_REQS-1){1'b0}}, 1'b1} << grant_idx_s)
                                          : {NUM_REQS{1'b0}};

    // Pointer register; reset value makes index 0 the first winner.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            last_grant_q <= IDX_W'(NUM_REQS - 1);
        end else if (en_i && grant_valid_o) begin
            last_grant_q <= grant_idx_s;
        end
    end

endmodule

// File: rtl/mem_arbiter.sv
// Shares one memory port among NUM_REQS caches: round-robin request mux into a
// one-entry output register, responses steered back by the low tag bits.
module mem_arbiter
    import mem_arb_pkg::*;
(
    input logic      clk_i,
    input logic      rst_ni,
    mem_arb_if.slave bus
);

    logic                load_en_s;
    logic                grant_valid_s;
    logic [NUM_REQS-1:0] grant_onehot_s;
    logic [SEL_BITS-1:0] grant_idx_s;
    logic [NUM_REQS-1:0] req_ready_s;
    logic [NUM_REQS-1:0] rsp_valid_s;
    logic [SEL_BITS-1:0] rsp_sel_s;
    mem_req_t            req_d;
    mem_req_t            out_q;
    logic                out_valid_q;

    assign load_en_s = ~out_valid_q | bus.mem_req_ready_i;

    rr_arbiter #(.NUM_REQS(NUM_REQS)) u_rr (
        .clk_i          (clk_i),
        .rst_ni         (rst_ni),
        .req_i          (bus.req_valid_i),
        .en_i           (load_en_s),
        .grant_valid_o  (grant_valid_s),
        .grant_onehot_o (grant_onehot_s),
        .grant_idx_o    (grant_idx_s)
    );

    assign req_ready_s = {NUM_REQS{load_en_s}} & grant_onehot_s;

    // AND-OR mux of the granted requester's payload; the index is appended below its tag.
    always_comb begin
        req_d = '0;
        for (int i = 0; i < NUM_REQS; i++) begin
            req_d.rw     = req_d.rw | (bus.req_rw_i[i] & grant_onehot_s[i]);
            req_d.byteen = req_d.byteen | (bus.req_byteen_i[i*BYTEEN_WIDTH +: BYTEEN_WIDTH]
                                           & {BYTEEN_WIDTH{grant_onehot_s[i]}});
            req_d.addr   = req_d.addr | (bus.req_addr_i[i*ADDR_WIDTH +: ADDR_WIDTH]
                                         & {ADDR_WIDTH{grant_onehot_s[i]}});
            req_d.data   = req_d.data | (bus.req_data_i[i*DATA_WIDTH +: DATA_WIDTH]
                                         & {DATA_WIDTH{grant_onehot_s[i]}});
            req_d.tag    = req_d.tag | ({bus.req_tag_i[i*TAG_IN_WIDTH +: TAG_IN_WIDTH], SEL_BITS'(i)}
                                        & {TAG_OUT_WIDTH{grant_onehot_s[i]}});
        end
    end

    // Output stage: refills whenever empty or draining, so drain+load has no bubble.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            out_valid_q <= 1'b0;
            out_q       <= '0;
        end else if (load_en_s) begin
            out_valid_q <= grant_valid_s;
            if (grant_valid_s) begin
                out_q <= req_d;
            end
        end
    end

    // Response steering by the index bits carried in the low tag bits.
    always_comb begin
        rsp_valid_s = '0;
        for (int k = 0; k < NUM_REQS; k++) begin
            rsp_valid_s[k] = bus.mem_rsp_valid_i & (int'(rsp_sel_s) == k);
        end
    end

    assign rsp_sel_s           = bus.mem_rsp_tag_i[SEL_BITS-1:0];
    assign bus.rsp_valid_o     = rsp_valid_s;
    assign bus.rsp_data_o      = bus.mem_rsp_data_i;
    assign bus.rsp_tag_o       = bus.mem_rsp_tag_i[TAG_OUT_WIDTH-1:SEL_BITS];
    assign bus.mem_rsp_ready_o = (int'(rsp_sel_s) < NUM_REQS) ? bus.rsp_ready_i[rsp_sel_s] : 1'b1;

    assign bus.req_ready_o      = req_ready_s;
    assign bus.mem_req_valid_o  = out_valid_q;
    assign bus.mem_req_rw_o     = out_q.rw;
    assign bus.mem_req_byteen_o = out_q.byteen;
    assign bus.mem_req_addr_o   = out_q.addr;
    assign bus.mem_req_data_o   = out_q.data;
    assign bus.mem_req_tag_o    = out_q.tag;

    mem_arbiter_chk u_chk (
        .clk_i           (clk_i),
        .rst_ni          (rst_ni),
        .mem_req_valid_i (out_valid_q),
        .mem_req_ready_i (bus.mem_req_ready_i),
        .payload_i       (out_q),
        .req_ready_i     (req_ready_s),
        .mem_rsp_valid_i (bus.mem_rsp_valid_i),
        .rsp_sel_i       (rsp_sel_s)
    );

endmodule
